// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch, data access and the test loader.
// Fetch starvation is bounded by STARVE_LIMIT consecutive data grants while fetch waits.
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   // fetch request / response
   input  logic        if_req_valid,
   input  logic [31:0] if_addr,
   output logic        if_req_ready,
   output logic        if_resp_valid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   // data request / response
   input  logic        d_req_valid,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic        d_unsigned,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_req_ready,
   output logic        d_resp_valid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   // test loader
   input  logic        setup_write,
   input  logic [31:0] setup_address,
   input  logic [31:0] setup_data_in,
   // shared memory port
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_size,
   output logic        mem_unsigned,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CntW-1:0] LimitC = CntW'(STARVE_LIMIT);

   typedef enum logic [1:0] {OwnNone, OwnFetch, OwnData} owner_e;

   owner_e          owner_q, owner_d;
   logic            err_q, err_d;
   logic            we_q, we_d;
   logic [CntW-1:0] starve_q, starve_d;

   logic setup_act, fetch_urgent, grant_fetch, grant_data;
   logic fetch_mis, data_mis;

   // Grant decision: setup, starved fetch, data, fetch
   always_comb begin
      setup_act    = setup_write & ~reset;
      fetch_urgent = if_req_valid & (starve_q == LimitC);
      grant_fetch  = ~reset & ~setup_write & if_req_valid & (fetch_urgent | ~d_req_valid);
      grant_data   = ~reset & ~setup_write & d_req_valid & ~fetch_urgent;
   end

   always_comb begin
      fetch_mis = |if_addr[1:0];
      unique case (d_size)
         2'b00:   data_mis = 1'b0;
         2'b01:   data_mis = d_addr[0];
         2'b10:   data_mis = |d_addr[1:0];
         default: data_mis = 1'b1;
      endcase
   end

   always_comb begin
      if_req_ready = grant_fetch;
      d_req_ready  = grant_data;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_size     = 2'b00;
      mem_unsigned = 1'b0;
      if (setup_act) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = setup_address;
         mem_wdata = setup_data_in;
         mem_size  = 2'b10;
      end else if (grant_fetch) begin
         // Misaligned requests are accepted but never reach memory
         mem_en       = ~fetch_mis;
         mem_addr     = if_addr;
         mem_size     = 2'b10;
         mem_unsigned = 1'b1;
      end else if (grant_data) begin
         mem_en       = ~data_mis;
         mem_we       = d_we;
         mem_addr     = d_addr;
         mem_wdata    = d_wdata;
         mem_size     = d_size;
         mem_unsigned = d_unsigned;
      end
   end

   always_comb begin
      if_resp_valid = 1'b0;
      if_rdata      = '0;
      if_err        = 1'b0;
      d_resp_valid  = 1'b0;
      d_rdata       = '0;
      d_err         = 1'b0;
      if (!reset) begin
         unique case (owner_q)
            OwnFetch: begin
               if_resp_valid = 1'b1;
               if_err        = err_q;
               if_rdata      = err_q ? '0 : mem_rdata;
            end
            OwnData: begin
               d_resp_valid = 1'b1;
               d_err        = err_q;
               d_rdata      = (err_q | we_q) ? '0 : mem_rdata;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      owner_d  = OwnNone;
      err_d    = 1'b0;
      we_d     = 1'b0;
      starve_d = starve_q;
      if (grant_fetch) begin
         owner_d = OwnFetch;
         err_d   = fetch_mis;
      end else if (grant_data) begin
         owner_d = OwnData;
         err_d   = data_mis;
         we_d    = d_we;
      end
      if (!setup_write) begin
         if (!if_req_valid || grant_fetch) begin
            starve_d = '0;
         end else if (grant_data && starve_q != LimitC) begin
            starve_d = starve_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         owner_q  <= OwnNone;
         err_q    <= 1'b0;
         we_q     <= 1'b0;
         starve_q <= '0;
      end else begin
         owner_q  <= owner_d;
         err_q    <= err_d;
         we_q     <= we_d;
         starve_q <= starve_d;
      end
   end

endmodule
